// File: rtl/ddp_seg_engine.sv
// DDP segmenter: splits one RDMAP message into DDP segments of at most MAX_SEG_BEATS beats,
// tags each with a DDP header, and tracks a per-queue MSN. Optional counters: DDP_SEG_STATS_EN.
module ddp_seg_engine #(
   parameter int DATA_W        = 256,
   parameter int HDR_W         = 48,
   parameter int NUM_Q         = 4,
   parameter int QN_W          = 4,
   parameter int MAX_SEG_BEATS = 16,
   parameter int LEN_W         = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              hdrValid,
   output logic              hdrReady,
   input  logic [HDR_W-1:0]  hdrRdmap,
   input  logic [7:0]        hdrCtrl,
   input  logic [QN_W-1:0]   hdrQn,
   input  logic [LEN_W-1:0]  hdrLen,
   input  logic [NUM_Q-1:0]  qFull,
   input  logic              dataValid,
   output logic              dataReady,
   input  logic [DATA_W-1:0] dataIn,
   output logic              segValid,
   input  logic              segReady,
   output logic [DATA_W-1:0] segData,
   output logic              segSop,
   output logic              segEop,
   output logic [31:0]       segDdpHdr,
   output logic [HDR_W-1:0]  segRdmap,
   output logic [15:0]       segMsn,
   output logic              doneValid,
   output logic [QN_W-1:0]   doneQn,
   output logic              doneErr,
`ifdef DDP_SEG_STATS_EN
   input  logic [QN_W-1:0]   statSel,
   output logic [31:0]       statCnt,
`endif
   output logic [1:0]        dbgState
);

   localparam int CNT_W = (MAX_SEG_BEATS > 1) ? $clog2(MAX_SEG_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SEG_BEATS - 1);
   localparam logic [QN_W:0]    NUMQ_X   = (QN_W + 1)'(NUM_Q);
   localparam logic [LEN_W:0]   MAXSEG_X = (LEN_W + 1)'(MAX_SEG_BEATS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DROP = 2'd2, S_DONE = 2'd3} state_t;

   state_t             r_state, w_next;
   logic [HDR_W-1:0]   r_rdmap;
   logic [7:0]         r_ctrl;
   logic [QN_W-1:0]    r_qn;
   logic [LEN_W-1:0]   r_rem;
   logic [15:0]        r_mo;
   logic [6:0]         r_seq;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err;
   logic [15:0]        r_msn [NUM_Q];
   logic [15:0]        r_seg_msn;
   logic               r_seg_valid, r_seg_sop, r_seg_eop, r_seg_last;
   logic [DATA_W-1:0]  r_seg_data;
   logic [31:0]        r_seg_hdr;

   logic               w_hdr_ready, w_data_ready, w_hdr_acc, w_xfer_acc;
   logic               w_qn_bad, w_qfull_sel, w_sop, w_eop, w_lastseg;
   logic [15:0]        w_msn_sel;

   assign w_qn_bad   = ({1'b0, hdrQn} >= NUMQ_X);
   assign w_hdr_acc  = hdrValid & w_hdr_ready;
   assign w_xfer_acc = (r_state == S_XFER) & dataValid & w_data_ready;
   assign w_sop      = (r_cnt == '0);
   assign w_eop      = (r_cnt == CNT_LAST) | (r_rem == LEN_W'(1));
   // Final segment when everything still to come fits in one segment.
   assign w_lastseg  = ({1'b0, r_rem} <= MAXSEG_X);

   always_comb begin
      w_qfull_sel = 1'b0;
      w_msn_sel   = '0;
      for (int i = 0; i < NUM_Q; i++) begin
         if (hdrQn == QN_W'(i)) begin
            w_qfull_sel = qFull[i];
            w_msn_sel   = r_msn[i];
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_hdr_ready  = 1'b0;
      w_data_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_hdr_ready = reset & (w_qn_bad | ~w_qfull_sel);
            if (hdrValid & w_hdr_ready) begin
               if (hdrLen == '0)  w_next = S_DONE;
               else if (w_qn_bad) w_next = S_DROP;
               else               w_next = S_XFER;
            end
         end
         S_XFER: begin
            // Stop pulling beats once the whole message has been taken in.
            w_data_ready = (r_rem != '0) & (~r_seg_valid | segReady);
            if (r_seg_valid & segReady & r_seg_last) w_next = S_DONE;
         end
         S_DROP: begin
            w_data_ready = 1'b1;
            if (dataValid & (r_rem == LEN_W'(1))) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_rdmap     <= '0;
         r_ctrl      <= '0;
         r_qn        <= '0;
         r_rem       <= '0;
         r_mo        <= '0;
         r_seq       <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_seg_msn   <= '0;
         r_seg_valid <= 1'b0;
         r_seg_sop   <= 1'b0;
         r_seg_eop   <= 1'b0;
         r_seg_last  <= 1'b0;
         r_seg_data  <= '0;
         r_seg_hdr   <= '0;
         for (int i = 0; i < NUM_Q; i++) r_msn[i] <= '0;
      end else begin
         r_state <= w_next;
         if (w_hdr_acc) begin
            r_rdmap   <= hdrRdmap;
            r_ctrl    <= hdrCtrl;
            r_qn      <= hdrQn;
            r_rem     <= hdrLen;
            r_mo      <= '0;
            r_seq     <= '0;
            r_cnt     <= '0;
            r_err     <= (hdrLen == '0) | w_qn_bad;
            r_seg_msn <= w_msn_sel;
         end
         if (w_xfer_acc) begin
            r_seg_valid <= 1'b1;
            r_seg_data  <= dataIn;
            r_seg_sop   <= w_sop;
            r_seg_eop   <= w_eop;
            r_seg_last  <= (r_rem == LEN_W'(1));
            if (w_sop) r_seg_hdr <= {w_lastseg, r_seq, r_ctrl, r_mo};
            if (w_eop) begin
               r_cnt <= '0;
               r_seq <= r_seq + 7'd1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
            r_rem <= r_rem - LEN_W'(1);
            r_mo  <= r_mo + 16'd1;
         end else if (r_seg_valid & segReady) begin
            r_seg_valid <= 1'b0;
         end
         if ((r_state == S_DROP) & dataValid) r_rem <= r_rem - LEN_W'(1);
         if ((r_state == S_DONE) & ~r_err) begin
            for (int i = 0; i < NUM_Q; i++)
               if (r_qn == QN_W'(i)) r_msn[i] <= r_msn[i] + 16'd1;
         end
      end
   end

`ifdef DDP_SEG_STATS_EN
   logic [31:0] r_stat [NUM_Q];
   logic [31:0] r_stat_out;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_stat_out <= '0;
         for (int i = 0; i < NUM_Q; i++) r_stat[i] <= '0;
      end else begin
         r_stat_out <= '0;
         for (int i = 0; i < NUM_Q; i++) begin
            if (r_seg_valid & segReady & r_seg_sop & (r_qn == QN_W'(i))) r_stat[i] <= r_stat[i] + 32'd1;
            if (statSel == QN_W'(i)) r_stat_out <= r_stat[i];
         end
      end
   end
   assign statCnt = r_stat_out;
`endif

   assign hdrReady  = w_hdr_ready;
   assign dataReady = w_data_ready;
   assign segValid  = r_seg_valid;
   assign segData   = r_seg_data;
   assign segSop    = r_seg_sop;
   assign segEop    = r_seg_eop;
   assign segDdpHdr = r_seg_hdr;
   assign segRdmap  = r_rdmap;
   assign segMsn    = r_seg_msn;
   assign doneValid = (r_state == S_DONE);
   assign doneQn    = doneValid ? r_qn : '0;
   assign doneErr   = doneValid & r_err;
   assign dbgState  = r_state;

endmodule

// File: tb/tb_ddp_seg_engine.sv
// Directed bench for ddp_seg_engine (MAX_SEG_BEATS=4): segmentation, MSN, backpressure,
// qFull gating, dropped messages and mid-message reset.
module tb_ddp_seg_engine;

   localparam int DATA_W = 256, HDR_W = 48, NUM_Q = 4, QN_W = 4, MAX_SEG_BEATS = 4, LEN_W = 16;

   logic              clock, reset;
   logic              hdrValid, hdrReady;
   logic [HDR_W-1:0]  hdrRdmap;
   logic [7:0]        hdrCtrl;
   logic [QN_W-1:0]   hdrQn;
   logic [LEN_W-1:0]  hdrLen;
   logic [NUM_Q-1:0]  qFull;
   logic              dataValid, dataReady;
   logic [DATA_W-1:0] dataIn;
   logic              segValid, segReady, segSop, segEop;
   logic [DATA_W-1:0] segData;
   logic [31:0]       segDdpHdr;
   logic [HDR_W-1:0]  segRdmap;
   logic [15:0]       segMsn;
   logic              doneValid, doneErr;
   logic [QN_W-1:0]   doneQn;
   logic [1:0]        dbgState;

   int checks = 0;
   int errors = 0;
   logic [49:0]       exp_q[$];
   logic [DATA_W-1:0] exp_d_q[$];

   ddp_seg_engine #(
      .DATA_W(DATA_W), .HDR_W(HDR_W), .NUM_Q(NUM_Q), .QN_W(QN_W),
      .MAX_SEG_BEATS(MAX_SEG_BEATS), .LEN_W(LEN_W)
   ) dut (
      .clock(clock), .reset(reset),
      .hdrValid(hdrValid), .hdrReady(hdrReady), .hdrRdmap(hdrRdmap), .hdrCtrl(hdrCtrl),
      .hdrQn(hdrQn), .hdrLen(hdrLen), .qFull(qFull),
      .dataValid(dataValid), .dataReady(dataReady), .dataIn(dataIn),
      .segValid(segValid), .segReady(segReady), .segData(segData), .segSop(segSop),
      .segEop(segEop), .segDdpHdr(segDdpHdr), .segRdmap(segRdmap), .segMsn(segMsn),
      .doneValid(doneValid), .doneQn(doneQn), .doneErr(doneErr), .dbgState(dbgState)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DATA_W-1:0] beat(input logic [7:0] tag, input int i);
      return {224'h0, tag, 8'h00, 16'(i)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_seg(input logic [7:0] tag, input int first, input int n,
                             input logic [31:0] hdr, input logic [15:0] msn);
      for (int k = 0; k < n; k++) begin
         exp_d_q.push_back(beat(tag, first + k));
         exp_q.push_back({(k == 0), (k == n - 1), hdr, msn});
      end
   endtask

   task automatic send_hdr(input logic [QN_W-1:0] qn, input logic [LEN_W-1:0] len,
                           input logic [7:0] ctrl, input logic [HDR_W-1:0] rd);
      int n = 0;
      hdrValid = 1'b1; hdrQn = qn; hdrLen = len; hdrCtrl = ctrl; hdrRdmap = rd;
      @(negedge clock);
      while (!hdrReady && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("hdr_accept", 64'(hdrReady), 64'(1));
      @(posedge clock); #1;
      hdrValid = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] tag, input int len, input bit toggle);
      int   i = 0;
      int   cyc = 0;
      logic acc;
      while (i < len && cyc < 200) begin
         dataValid = 1'b1;
         dataIn    = beat(tag, i);
         segReady  = (cyc % 2 == 0) || !toggle;
         @(negedge clock);
         acc = dataReady;
         @(posedge clock); #1;
         if (acc) i++;
         cyc++;
      end
      dataValid = 1'b0;
      segReady  = 1'b1;
      check("beats_accepted", 64'(i), 64'(len));
   endtask

   task automatic wait_done(input logic [QN_W-1:0] qn, input logic err);
      int n = 0;
      @(negedge clock);
      while (!doneValid && n < 60) begin
         @(negedge clock);
         n++;
      end
      check("done_seen", 64'(doneValid), 64'(1));
      check("done_qn", 64'(doneQn), 64'(qn));
      check("done_err", 64'(doneErr), 64'(err));
      @(negedge clock);
      check("done_one_cycle", 64'(doneValid), 64'(0));
      @(posedge clock); #1;
   endtask

   // Output monitor: every accepted beat against the expected queue; stalled beats must hold.
   logic              hold = 1'b0;
   logic [DATA_W-1:0] h_d;
   logic [49:0]       h_c;
   logic [DATA_W-1:0] ed;
   logic [49:0]       ec;

   always @(negedge clock) begin
      if (!reset) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid", 64'(segValid), 64'(1));
            check("hold_ctl", 64'({segSop, segEop, segDdpHdr, segMsn}), 64'(h_c));
            checks++;
            assert (segData === h_d) else begin
               errors++;
               $error("FAIL hold_data observed=%0h expected=%0h", segData, h_d);
            end
         end
         if (segValid && segReady) begin
            check("beat_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               ec = exp_q.pop_front();
               ed = exp_d_q.pop_front();
               check("seg_ctl", 64'({segSop, segEop, segDdpHdr, segMsn}), 64'(ec));
               checks++;
               assert (segData === ed) else begin
                  errors++;
                  $error("FAIL seg_data observed=%0h expected=%0h", segData, ed);
               end
            end
         end
         hold = segValid && !segReady;
         h_d  = segData;
         h_c  = {segSop, segEop, segDdpHdr, segMsn};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; hdrValid = 1'b0; hdrRdmap = '0; hdrCtrl = '0; hdrQn = '0; hdrLen = '0;
      qFull = '0; dataValid = 1'b0; dataIn = '0; segReady = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_seg_valid", 64'(segValid), 64'(0));
      check("rst_data_ready", 64'(dataReady), 64'(0));
      check("rst_hdr_ready", 64'(hdrReady), 64'(0));
      check("rst_done", 64'({doneValid, doneQn, doneErr}), 64'(0));
      check("rst_sop_eop", 64'({segSop, segEop}), 64'(0));
      check("rst_hdr", 64'(segDdpHdr), 64'(0));
      check("rst_rdmap", 64'(segRdmap), 64'(0));
      check("rst_msn", 64'(segMsn), 64'(0));
      check("rst_state", 64'(dbgState), 64'(0));
      reset = 1'b1;
      @(posedge clock); #1;

      // 10 beats on queue 1 -> 4/4/2 beats, MO 0/4/8, seq 0/1/2, L on last
      expect_seg(8'd1, 0, 4, 32'h005A_0000, 16'd0);
      expect_seg(8'd1, 4, 4, 32'h015A_0004, 16'd0);
      expect_seg(8'd1, 8, 2, 32'h825A_0008, 16'd0);
      send_hdr(4'd1, 16'd10, 8'h5A, 48'h1111_2222_3333);
      check("rdmap_latched", 64'(segRdmap), 64'h1111_2222_3333);
      check("state_xfer", 64'(dbgState), 64'(1));
      send_data(8'd1, 10, 1'b0);
      wait_done(4'd1, 1'b0);

      // Second message on queue 1 gets MSN 1; queue 2 still at MSN 0
      expect_seg(8'd2, 0, 4, 32'h0033_0000, 16'd1);
      expect_seg(8'd2, 4, 4, 32'h0133_0004, 16'd1);
      expect_seg(8'd2, 8, 2, 32'h8233_0008, 16'd1);
      send_hdr(4'd1, 16'd10, 8'h33, 48'hAAAA_0000_0002);
      send_data(8'd2, 10, 1'b0);
      wait_done(4'd1, 1'b0);
      expect_seg(8'd3, 0, 3, 32'h8011_0000, 16'd0);
      send_hdr(4'd2, 16'd3, 8'h11, 48'hAAAA_0000_0003);
      send_data(8'd3, 3, 1'b0);
      wait_done(4'd2, 1'b0);

      // segReady toggling during a 10-beat message on queue 1 (MSN 2)
      expect_seg(8'd4, 0, 4, 32'h0077_0000, 16'd2);
      expect_seg(8'd4, 4, 4, 32'h0177_0004, 16'd2);
      expect_seg(8'd4, 8, 2, 32'h8277_0008, 16'd2);
      send_hdr(4'd1, 16'd10, 8'h77, 48'hAAAA_0000_0004);
      send_data(8'd4, 10, 1'b1);
      wait_done(4'd1, 1'b0);

      // qFull[2] blocks the header; clearing it admits the header in the same cycle
      qFull = 4'b0100;
      hdrValid = 1'b1; hdrQn = 4'd2; hdrLen = 16'd5; hdrCtrl = 8'h22; hdrRdmap = 48'h5;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check("hdr_ready_qfull", 64'(hdrReady), 64'(0));
      end
      @(posedge clock); #1;
      qFull = 4'b0000;
      #1;
      check("hdr_ready_qfull_clr", 64'(hdrReady), 64'(1));
      expect_seg(8'd5, 0, 4, 32'h0022_0000, 16'd1);
      expect_seg(8'd5, 4, 1, 32'h8122_0004, 16'd1);
      send_hdr(4'd2, 16'd5, 8'h22, 48'h5);
      qFull = 4'b0100;
      send_data(8'd5, 5, 1'b0);
      wait_done(4'd2, 1'b0);
      qFull = 4'b0000;

      // Out-of-range queue: beats swallowed, error completion
      send_hdr(4'd7, 16'd3, 8'h01, 48'h7);
      check("state_drop", 64'(dbgState), 64'(2));
      send_data(8'd9, 3, 1'b0);
      wait_done(4'd7, 1'b1);

      // Zero length: immediate error completion, MSN untouched (queue 1 stays at 3)
      send_hdr(4'd1, 16'd0, 8'h02, 48'h8);
      wait_done(4'd1, 1'b1);
      expect_seg(8'd6, 0, 4, 32'h8044_0000, 16'd3);
      send_hdr(4'd1, 16'd4, 8'h44, 48'h9);
      send_data(8'd6, 4, 1'b0);
      wait_done(4'd1, 1'b0);

      // Reset in the middle of a stalled segment
      send_hdr(4'd1, 16'd10, 8'h66, 48'hA);
      dataValid = 1'b1; dataIn = beat(8'd7, 0); segReady = 1'b0;
      @(posedge clock); #1;
      dataIn = beat(8'd7, 1);
      @(posedge clock); #1;
      check("mid_seg_valid", 64'(segValid), 64'(1));
      reset = 1'b0; dataValid = 1'b0;
      @(posedge clock); #1;
      check("mid_rst_seg_valid", 64'(segValid), 64'(0));
      check("mid_rst_state", 64'(dbgState), 64'(0));
      check("mid_rst_done", 64'(doneValid), 64'(0));
      reset = 1'b1; segReady = 1'b1;
      #1;
      check("hdr_ready_after_rst", 64'(hdrReady), 64'(1));
      @(negedge clock);
      check("no_done_after_rst", 64'(doneValid), 64'(0));
      @(posedge clock); #1;
      expect_seg(8'd8, 0, 2, 32'h8066_0000, 16'd0);
      send_hdr(4'd1, 16'd2, 8'h66, 48'hB);
      send_data(8'd8, 2, 1'b0);
      wait_done(4'd1, 1'b0);

      check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
